// File: rtl/lcd_timing_gen_if.sv
// Raster timing bundle from the LCD timing generator to the video-RAM read stage.
// Everything in it describes the same pixel in the same cycle.
interface lcd_timing_gen_if;
    logic [15:0] x;
    logic [15:0] y;
    logic        LCD_DEN;
    logic        LCD_HYNC;
    logic        LCD_SYNC;
    logic        line_start;
    logic        frame_start;
    logic        in_win;
    logic [15:0] win_x;
    logic [15:0] win_y;

    modport master (
        output x, y, LCD_DEN, LCD_HYNC, LCD_SYNC,
        output line_start, frame_start, in_win, win_x, win_y
    );

    modport slave (
        input x, y, LCD_DEN, LCD_HYNC, LCD_SYNC,
        input line_start, frame_start, in_win, win_x, win_y
    );
endinterface

// File: rtl/lcd_timing_gen.sv
// Raster timing generator for the RGB LCD path.
// Free-running pixel/line counters are decoded into one registered set of timing outputs.
module lcd_timing_gen #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 210,
    parameter int unsigned H_SYNC   = 20,
    parameter int unsigned H_BP     = 26,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 22,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 18,
    parameter int unsigned HS_POL   = 0,
    parameter int unsigned VS_POL   = 0,
    parameter int unsigned WIN_X0   = 272,
    parameter int unsigned WIN_Y0   = 112,
    parameter int unsigned WIN_W    = 256,
    parameter int unsigned WIN_H    = 256
) (
    input  logic             pixel_clk,
    input  logic             rst,
    lcd_timing_gen_if.master vid
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam logic        HS_ACT   = 1'(HS_POL);
    localparam logic        VS_ACT   = 1'(VS_POL);

    logic [15:0] h_cnt;
    logic [15:0] v_cnt;
    logic        h_last;
    logic        v_last;

    logic        den_p0;
    logic        hsync_p0;
    logic        vsync_p0;
    logic        line_start_p0;
    logic        frame_start_p0;
    logic        in_win_p0;
    logic [31:0] rel_x_p0;
    logic [31:0] rel_y_p0;
    logic [15:0] win_x_p0;
    logic [15:0] win_y_p0;

    assign h_last = (32'(h_cnt) == H_TOTAL - 1);
    assign v_last = (32'(v_cnt) == V_TOTAL - 1);

    // Stage p0: raster counters
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? 16'd0 : v_cnt + 16'd1;
        end else begin
            h_cnt <= h_cnt + 16'd1;
        end
    end

    // Window test by offset: positions left of / above the window wrap to huge
    // unsigned values, so one compare per axis covers both edges.
    always_comb begin
        den_p0         = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
        hsync_p0       = ((32'(h_cnt) >= HS_START) && (32'(h_cnt) < HS_END)) ? HS_ACT : ~HS_ACT;
        vsync_p0       = ((32'(v_cnt) >= VS_START) && (32'(v_cnt) < VS_END)) ? VS_ACT : ~VS_ACT;
        line_start_p0  = (h_cnt == 16'd0);
        frame_start_p0 = (h_cnt == 16'd0) && (v_cnt == 16'd0);
        rel_x_p0       = 32'(h_cnt) - WIN_X0;
        rel_y_p0       = 32'(v_cnt) - WIN_Y0;
        in_win_p0      = den_p0 && (rel_x_p0 < WIN_W) && (rel_y_p0 < WIN_H);
        win_x_p0       = '0;
        win_y_p0       = '0;
        if (in_win_p0) begin
            win_x_p0 = rel_x_p0[15:0];
            win_y_p0 = rel_y_p0[15:0];
        end
    end

    // Stage p1: registered outputs, one cycle behind the counters
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            vid.x           <= '0;
            vid.y           <= '0;
            vid.LCD_DEN     <= 1'b0;
            vid.LCD_HYNC    <= ~HS_ACT;
            vid.LCD_SYNC    <= ~VS_ACT;
            vid.line_start  <= 1'b0;
            vid.frame_start <= 1'b0;
            vid.in_win      <= 1'b0;
            vid.win_x       <= '0;
            vid.win_y       <= '0;
        end else begin
            vid.x           <= h_cnt;
            vid.y           <= v_cnt;
            vid.LCD_DEN     <= den_p0;
            vid.LCD_HYNC    <= hsync_p0;
            vid.LCD_SYNC    <= vsync_p0;
            vid.line_start  <= line_start_p0;
            vid.frame_start <= frame_start_p0;
            vid.in_win      <= in_win_p0;
            vid.win_x       <= win_x_p0;
            vid.win_y       <= win_y_p0;
        end
    end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Scoreboard bench for lcd_timing_gen: default timing, a scaled-down raster,
// and an active-high sync / edge-clipped window variant share one clock and reset.
module tb_lcd_timing_gen;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic        den;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
        logic        inw;
        logic [15:0] wx;
        logic [15:0] wy;
    } obs_t;

    typedef struct {
        int    due;
        int    inst;
        string tag;
        obs_t  v;
    } exp_t;

    logic pixel_clk = 1'b0;
    logic rst       = 1'b1;

    always #5 pixel_clk = ~pixel_clk;

    lcd_timing_gen_if ia();
    lcd_timing_gen_if ib();
    lcd_timing_gen_if ic();

    lcd_timing_gen u_a (.pixel_clk(pixel_clk), .rst(rst), .vid(ia));

    lcd_timing_gen #(
        .H_ACTIVE(8), .H_FP(3), .H_SYNC(2), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(1), .V_BP(1),
        .WIN_X0(2), .WIN_Y0(1), .WIN_W(4), .WIN_H(3)
    ) u_b (.pixel_clk(pixel_clk), .rst(rst), .vid(ib));

    lcd_timing_gen #(
        .HS_POL(1), .VS_POL(1), .WIN_X0(700), .WIN_W(200), .WIN_Y0(0)
    ) u_c (.pixel_clk(pixel_clk), .rst(rst), .vid(ic));

    int   tests = 0;
    int   fails = 0;
    int   edge_no = 0;
    int   run = 0;
    exp_t mq[$];
    exp_t dq[$];
    obs_t actv[3];

    function automatic obs_t pack(logic [15:0] x, logic [15:0] y, logic den, logic hs, logic vs,
                                  logic ls, logic fs, logic inw, logic [15:0] wx, logic [15:0] wy);
        obs_t o;
        o.x = x; o.y = y; o.den = den; o.hs = hs; o.vs = vs;
        o.ls = ls; o.fs = fs; o.inw = inw; o.wx = wx; o.wy = wy;
        return o;
    endfunction

    assign actv[0] = pack(ia.x, ia.y, ia.LCD_DEN, ia.LCD_HYNC, ia.LCD_SYNC,
                          ia.line_start, ia.frame_start, ia.in_win, ia.win_x, ia.win_y);
    assign actv[1] = pack(ib.x, ib.y, ib.LCD_DEN, ib.LCD_HYNC, ib.LCD_SYNC,
                          ib.line_start, ib.frame_start, ib.in_win, ib.win_x, ib.win_y);
    assign actv[2] = pack(ic.x, ic.y, ic.LCD_DEN, ic.LCD_HYNC, ic.LCD_SYNC,
                          ic.line_start, ic.frame_start, ic.in_win, ic.win_x, ic.win_y);

    function automatic string fmt(obs_t o);
        return $sformatf("x=%0d y=%0d den=%0b hs=%0b vs=%0b ls=%0b fs=%0b win=%0b wx=%0d wy=%0d",
                         o.x, o.y, o.den, o.hs, o.vs, o.ls, o.fs, o.inw, o.wx, o.wy);
    endfunction

    // Expected outputs for pixel number p since reset release, from the
    // textbook raster definition (pixel index -> column/line by division).
    function automatic obs_t model(int inst, int p, bit in_rst);
        int ha = 800, hfp = 210, hsw = 20, hbp = 26;
        int va = 480, vfp = 22, vsw = 5, vbp = 18;
        int hp = 0, vp = 0, wx0 = 272, wy0 = 112, ww = 256, wh = 256;
        int ht, vt, cx, cy;
        bit den, inw;
        obs_t o;
        if (inst == 1) begin
            ha = 8; hfp = 3; hsw = 2; hbp = 3;
            va = 6; vfp = 2; vsw = 1; vbp = 1;
            wx0 = 2; wy0 = 1; ww = 4; wh = 3;
        end else if (inst == 2) begin
            hp = 1; vp = 1; wx0 = 700; ww = 200; wy0 = 0;
        end
        if (in_rst) return pack(16'd0, 16'd0, 1'b0, ~1'(hp), ~1'(vp), 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        ht  = ha + hfp + hsw + hbp;
        vt  = va + vfp + vsw + vbp;
        cx  = p % ht;
        cy  = (p / ht) % vt;
        den = (cx < ha) && (cy < va);
        inw = den && (cx >= wx0) && (cx < wx0 + ww) && (cy >= wy0) && (cy < wy0 + wh);
        o.x   = 16'(cx);
        o.y   = 16'(cy);
        o.den = den;
        o.hs  = ((cx >= ha + hfp) && (cx < ha + hfp + hsw)) ? 1'(hp) : ~1'(hp);
        o.vs  = ((cy >= va + vfp) && (cy < va + vfp + vsw)) ? 1'(vp) : ~1'(vp);
        o.ls  = (cx == 0);
        o.fs  = (cx == 0) && (cy == 0);
        o.inw = inw;
        o.wx  = inw ? 16'(cx - wx0) : 16'd0;
        o.wy  = inw ? 16'(cy - wy0) : 16'd0;
        return o;
    endfunction

    task automatic check(string tag, obs_t got, obs_t req);
        tests++;
        if (got !== req) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s @edge %0d: got %s, required %s", tag, edge_no, fmt(got), fmt(req));
        end
    endtask

    task automatic dpush(string tag, int inst, int due, int x, int y, bit den, bit hs, bit vs,
                         bit ls, bit fs, bit inw, int wx, int wy);
        exp_t e;
        e.due  = due;
        e.inst = inst;
        e.tag  = tag;
        e.v    = pack(16'(x), 16'(y), den, hs, vs, ls, fs, inw, 16'(wx), 16'(wy));
        dq.push_back(e);
    endtask

    // Stimulus side: every edge enqueues the expected response of each instance
    initial forever begin
        @(posedge pixel_clk);
        edge_no++;
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            e.due  = edge_no;
            e.inst = i;
            e.tag  = $sformatf("raster_%0d", i);
            e.v    = model(i, run, rst);
            mq.push_back(e);
        end
        if (rst) run = 0;
        else     run++;
    end

    // Monitor: outputs are sampled mid-cycle and matched against the queues
    initial forever begin
        @(negedge pixel_clk);
        for (int i = 0; i < 3; i++) begin
            if (mq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_empty: got no entry, required one per instance");
            end else begin
                exp_t e;
                e = mq.pop_front();
                check(e.tag, actv[e.inst], e.v);
            end
        end
        while (dq.size() > 0 && dq[0].due <= edge_no) begin
            exp_t e;
            e = dq.pop_front();
            if (e.due < edge_no) begin
                tests++;
                fails++;
                $display("FAIL %s: checked at edge %0d, required edge %0d", e.tag, edge_no, e.due);
            end else begin
                check(e.tag, actv[e.inst], e.v);
            end
        end
    end

    initial begin
        int e0;
        int m;
        rst = 1'b1;
        repeat (5) @(posedge pixel_clk);
        dpush("a_reset", 0, 5, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        dpush("c_reset", 2, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge pixel_clk);
        rst = 1'b0;
        e0 = 6;

        dpush("a_first",     0, e0 + 0,    0,    0, 1, 1, 1, 1, 1, 0, 0,  0);
        dpush("c_first",     2, e0 + 0,    0,    0, 1, 0, 0, 1, 1, 0, 0,  0);
        dpush("b_win_tl",    1, e0 + 18,   2,    1, 1, 1, 1, 0, 0, 1, 0,  0);
        dpush("b_left_out",  1, e0 + 33,   1,    2, 1, 1, 1, 0, 0, 0, 0,  0);
        dpush("b_win_br",    1, e0 + 53,   5,    3, 1, 1, 1, 0, 0, 1, 3,  2);
        dpush("b_right_out", 1, e0 + 54,   6,    3, 1, 1, 1, 0, 0, 0, 0,  0);
        dpush("b_hsync",     1, e0 + 123,  11,   7, 0, 0, 1, 0, 0, 0, 0,  0);
        dpush("b_vsync",     1, e0 + 128,  0,    8, 0, 1, 0, 1, 0, 0, 0,  0);
        dpush("b_last",      1, e0 + 159,  15,   9, 0, 1, 1, 0, 0, 0, 0,  0);
        dpush("b_wrap",      1, e0 + 160,  0,    0, 1, 1, 1, 1, 1, 0, 0,  0);
        dpush("c_win_left",  2, e0 + 700,  700,  0, 1, 0, 0, 0, 0, 1, 0,  0);
        dpush("a_den_last",  0, e0 + 799,  799,  0, 1, 1, 1, 0, 0, 0, 0,  0);
        dpush("c_win_edge",  2, e0 + 799,  799,  0, 1, 0, 0, 0, 0, 1, 99, 0);
        dpush("a_den_off",   0, e0 + 800,  800,  0, 0, 1, 1, 0, 0, 0, 0,  0);
        dpush("c_win_clip",  2, e0 + 800,  800,  0, 0, 0, 0, 0, 0, 0, 0,  0);
        dpush("a_hs_before", 0, e0 + 1009, 1009, 0, 0, 1, 1, 0, 0, 0, 0,  0);
        dpush("a_hs_first",  0, e0 + 1010, 1010, 0, 0, 0, 1, 0, 0, 0, 0,  0);
        dpush("c_hs_high",   2, e0 + 1010, 1010, 0, 0, 1, 0, 0, 0, 0, 0,  0);
        dpush("a_hs_last",   0, e0 + 1029, 1029, 0, 0, 0, 1, 0, 0, 0, 0,  0);
        dpush("a_hs_after",  0, e0 + 1030, 1030, 0, 0, 1, 1, 0, 0, 0, 0,  0);
        dpush("a_line_end",  0, e0 + 1055, 1055, 0, 0, 1, 1, 0, 0, 0, 0,  0);
        dpush("a_line1",     0, e0 + 1056, 0,    1, 1, 1, 1, 1, 0, 0, 0,  0);

        // Small raster sits at x=4, y=5 when the one-cycle reset is applied
        repeat (2165) @(posedge pixel_clk);
        m = e0 + 2165;
        dpush("a_mid_reset", 0, m,     0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        dpush("b_mid_reset", 1, m,     0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        dpush("b_restart",   1, m + 1, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0);
        @(negedge pixel_clk);
        rst = 1'b1;
        @(negedge pixel_clk);
        rst = 1'b0;
        repeat (300) @(negedge pixel_clk);

        tests++;
        if (dq.size() != 0) begin
            fails++;
            $display("FAIL directed_drain: got %0d pending, required 0", dq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
